// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer around a single-step 32-bit ALU with a start/done handshake.
// N-bit shifts/rotates are built by feeding the ALU's 1-bit shift result back into its A input.
module alu_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       OpIn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   ShAmt,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    output logic [3:0]       AluOp,
    input  logic [WIDTH-1:0] AluOut,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             ZeroOut,
    output logic             Err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;     // doubles as the shift accumulator
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    function automatic logic is_arith(input logic [3:0] op);
        return (op <= 4'd4);
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        case (op)
            4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    cnt_d = ShAmt;
                    err_d = 1'b0;
                    if (is_arith(OpIn)) begin
                        alu_a_d  = A;
                        alu_b_d  = B;
                        alu_op_d = OpIn;
                        state_d  = EXEC;
                    end else if (is_shift(OpIn)) begin
                        if (ShAmt != '0) begin
                            alu_a_d  = A;
                            alu_b_d  = B;
                            alu_op_d = OpIn;
                            state_d  = SHIFT;
                        end else begin
                            result_d = A;
                            zero_d   = (A == '0);
                            state_d  = FIN;
                        end
                    end else begin
                        result_d = '0;
                        zero_d   = 1'b1;
                        err_d    = 1'b1;
                        state_d  = FIN;
                    end
                end
            end
            EXEC: begin
                result_d = AluOut;
                zero_d   = (AluOut == '0);
                state_d  = FIN;
            end
            SHIFT: begin
                cnt_d = cnt_q - SHW'(1);
                // Last pass: capture the result but leave AluA holding its final operand.
                if (cnt_q == SHW'(1)) begin
                    result_d = AluOut;
                    zero_d   = (AluOut == '0);
                    state_d  = FIN;
                end else begin
                    alu_a_d = AluOut;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign AluA    = alu_a_q;
    assign AluB    = alu_b_q;
    assign AluOp   = alu_op_q;
    assign Busy    = (state_q == EXEC) || (state_q == SHIFT);
    assign Done    = (state_q == FIN);
    assign Result  = result_q;
    assign ZeroOut = zero_q;
    assign Err     = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: a behavioural single-step ALU closes the loop,
// a vector table covers each op, and hand-written sequences cover Start/Reset corner cases.
module tb_alu_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Start;
    logic [3:0]       OpIn;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [SHW-1:0]   ShAmt;
    logic [WIDTH-1:0] AluA;
    logic [WIDTH-1:0] AluB;
    logic [3:0]       AluOp;
    logic [WIDTH-1:0] AluOut;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             ZeroOut;
    logic             Err;

    alu_seq_ctrl #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .OpIn(OpIn),
        .A(A), .B(B), .ShAmt(ShAmt),
        .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluOut(AluOut),
        .Busy(Busy), .Done(Done), .Result(Result), .ZeroOut(ZeroOut), .Err(Err)
    );

    always #5 Clk = ~Clk;

    // Single-step ALU the sequencer drives
    always_comb begin
        AluOut = '0;
        case (AluOp)
            4'b0000: AluOut = AluA + AluB;
            4'b0001: AluOut = AluA - AluB;
            4'b0010: AluOut = AluA & AluB;
            4'b0011: AluOut = AluA | AluB;
            4'b0100: AluOut = ~AluA;
            4'b1000: AluOut = {AluA[WIDTH-1], AluA[WIDTH-1:1]};
            4'b1010: AluOut = {1'b0, AluA[WIDTH-1:1]};
            4'b1001: AluOut = {AluA[WIDTH-2:0], 1'b0};
            4'b1100: AluOut = {AluA[WIDTH-2:0], AluA[WIDTH-1]};
            4'b1101: AluOut = {AluA[0], AluA[WIDTH-1:1]};
            default: AluOut = '0;
        endcase
    end

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [SHW-1:0]   sh;
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             err;
        int               lat;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    // Issue one op, then scramble inputs and wait (bounded) for Done.
    task automatic do_op(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [SHW-1:0] sh, output int lat, output int busy_cnt);
        @(negedge Clk);
        Start = 1'b1; OpIn = op; A = a; B = b; ShAmt = sh;
        @(posedge Clk);
        #1;
        Start = 1'b0; OpIn = 4'b0111; A = $urandom; B = $urandom; ShAmt = SHW'($urandom);
        lat = -1;
        busy_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            if (Busy) busy_cnt++;
            if (Done) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat, busy_cnt, done_cnt, d1, d2;
        logic [WIDTH-1:0] r1, r2;

        Reset = 1'b1; Start = 1'b0; OpIn = '0; A = '0; B = '0; ShAmt = '0;

        vecs[0]  = '{4'b0000, 32'd5,         32'd7,         5'd0,  32'd12,        1'b0, 1'b0, 2};
        vecs[1]  = '{4'b0001, 32'd7,         32'd7,         5'd0,  32'd0,         1'b1, 1'b0, 2};
        vecs[2]  = '{4'b0010, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0,  32'h00F0_1234, 1'b0, 1'b0, 2};
        vecs[3]  = '{4'b0011, 32'hA000_0000, 32'h0000_000B, 5'd0,  32'hA000_000B, 1'b0, 1'b0, 2};
        vecs[4]  = '{4'b0100, 32'h0F0F_0F0F, 32'h1234_5678, 5'd0,  32'hF0F0_F0F0, 1'b0, 1'b0, 2};
        vecs[5]  = '{4'b1001, 32'h0000_0001, 32'd0,         5'd4,  32'h0000_0010, 1'b0, 1'b0, 5};
        vecs[6]  = '{4'b1000, 32'h8000_0000, 32'd0,         5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 32};
        vecs[7]  = '{4'b1010, 32'h8000_0000, 32'd0,         5'd31, 32'h0000_0001, 1'b0, 1'b0, 32};
        vecs[8]  = '{4'b1101, 32'h0000_0001, 32'd0,         5'd1,  32'h8000_0000, 1'b0, 1'b0, 2};
        vecs[9]  = '{4'b1100, 32'h8000_0001, 32'd0,         5'd4,  32'h0000_0018, 1'b0, 1'b0, 5};
        vecs[10] = '{4'b1100, 32'hDEAD_BEEF, 32'd0,         5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0, 1};
        vecs[11] = '{4'b0111, 32'h1234_5678, 32'd9,         5'd3,  32'd0,         1'b1, 1'b1, 1};
        vecs[12] = '{4'b0000, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0,         1'b1, 1'b0, 2};
        vecs[13] = '{4'b1001, 32'h0000_0001, 32'd0,         5'd31, 32'h8000_0000, 1'b0, 1'b0, 32};
        vecs[14] = '{4'b1000, 32'h4000_0000, 32'd0,         5'd3,  32'h0800_0000, 1'b0, 1'b0, 4};
        vecs[15] = '{4'b1101, 32'h1234_5678, 32'd0,         5'd31, 32'h2468_ACF0, 1'b0, 1'b0, 32};
        vecs[16] = '{4'b0000, 32'd3,         32'd4,         5'd9,  32'd7,         1'b0, 1'b0, 2};
        vecs[17] = '{4'b1111, 32'd1,         32'd1,         5'd0,  32'd0,         1'b1, 1'b1, 1};

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_busy",   {31'd0, Busy},    32'd0);
        check("reset_done",   {31'd0, Done},    32'd0);
        check("reset_err",    {31'd0, Err},     32'd0);
        check("reset_zero",   {31'd0, ZeroOut}, 32'd0);
        check("reset_result", Result,           32'd0);
        check("reset_alua",   AluA,             32'd0);
        check("reset_alub",   AluB,             32'd0);
        check("reset_aluop",  {28'd0, AluOp},   32'd0);
        Reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, lat, busy_cnt);
            $display("vec %0d: op=%b a=0x%08h b=0x%08h sh=%0d -> result=0x%08h zero=%0b err=%0b done_cycle=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, Result, ZeroOut, Err, lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy_cycles", i), busy_cnt, vecs[i].lat - 1);
            check($sformatf("vec%0d_result", i), Result, vecs[i].res);
            check($sformatf("vec%0d_zero", i), {31'd0, ZeroOut}, {31'd0, vecs[i].zero});
            check($sformatf("vec%0d_err", i), {31'd0, Err}, {31'd0, vecs[i].err});
            @(negedge Clk);
            check($sformatf("vec%0d_done_single", i), {31'd0, Done}, 32'd0);
        end

        // Start pulses during an 8-cycle shift and during FIN must be ignored
        @(negedge Clk);
        Start = 1'b1; OpIn = 4'b1001; A = 32'h1; B = '0; ShAmt = 5'd8;
        @(posedge Clk);
        #1;
        Start = 1'b0; OpIn = 4'b0000; A = '0; B = '0; ShAmt = 5'd1;
        done_cnt = 0; d1 = -1; r1 = '0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge Clk);
            if (Done) begin
                done_cnt++;
                if (d1 < 0) begin
                    d1 = c;
                    r1 = Result;
                end
            end
            if (c == 2 || c == 9) Start = 1'b1;
            if (c == 4 || c == 10) Start = 1'b0;
        end
        $display("seq ignore_start: done_pulses=%0d done_cycle=%0d result=0x%08h", done_cnt, d1, r1);
        check("ign_done_count", done_cnt, 1);
        check("ign_done_cycle", d1, 9);
        check("ign_result", r1, 32'h0000_0100);
        check("ign_result_held", Result, 32'h0000_0100);
        check("ign_idle_busy", {31'd0, Busy}, 32'd0);

        // Start held high re-triggers on the first IDLE cycle with the operands present then
        @(negedge Clk);
        Start = 1'b1; OpIn = 4'b0000; A = 32'd2; B = 32'd3; ShAmt = '0;
        @(posedge Clk);
        #1;
        A = 32'd10;
        done_cnt = 0; d1 = -1; d2 = -1; r1 = '0; r2 = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge Clk);
            if (Done) begin
                done_cnt++;
                if (d1 < 0) begin
                    d1 = c; r1 = Result;
                end else if (d2 < 0) begin
                    d2 = c; r2 = Result;
                end
            end
            if (c == 4) Start = 1'b0;
        end
        $display("seq held_start: done_pulses=%0d first=%0d (0x%08h) second=%0d (0x%08h)", done_cnt, d1, r1, d2, r2);
        check("held_done_count", done_cnt, 2);
        check("held_first_cycle", d1, 2);
        check("held_first_result", r1, 32'd5);
        check("held_second_cycle", d2, 5);
        check("held_second_result", r2, 32'd13);

        // Reset in the 3rd SHIFT cycle aborts the operation
        @(negedge Clk);
        Start = 1'b1; OpIn = 4'b1001; A = 32'h1; B = '0; ShAmt = 5'd8;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        check("abort_busy_before", {31'd0, Busy}, 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        check("abort_busy",   {31'd0, Busy},    32'd0);
        check("abort_done",   {31'd0, Done},    32'd0);
        check("abort_result", Result,           32'd0);
        check("abort_aluop",  {28'd0, AluOp},   32'd0);
        check("abort_alua",   AluA,             32'd0);
        check("abort_zero",   {31'd0, ZeroOut}, 32'd0);
        Reset = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            if (Done) done_cnt++;
        end
        $display("seq reset_abort: done_pulses_after=%0d result=0x%08h", done_cnt, Result);
        check("abort_no_done", done_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
